// File: rtl/muldiv_ctl_if.sv
// Execute-stage view of the HI/LO multiply/divide unit: operation request,
// mthi/mtlo writes, mfhi/mflo hazard, and the HI/LO/status return path.
interface muldiv_ctl_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             Start_EX;
    logic [1:0]       Op_EX;
    logic [WIDTH-1:0] SrcA_EX;
    logic [WIDTH-1:0] SrcB_EX;
    logic             ReadHiLo_EX;
    logic             WrHi_EX;
    logic             WrLo_EX;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;
    logic             Stall_EX;

    modport master (
        output flush, Start_EX, Op_EX, SrcA_EX, SrcB_EX, ReadHiLo_EX, WrHi_EX, WrLo_EX,
        input  Hi, Lo, Busy, Done, Stall_EX
    );

    modport slave (
        input  flush, Start_EX, Op_EX, SrcA_EX, SrcB_EX, ReadHiLo_EX, WrHi_EX, WrLo_EX,
        output Hi, Lo, Busy, Done, Stall_EX
    );
endinterface

// File: rtl/muldiv_ctl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: magnitudes are
// iterated for WIDTH cycles, then one SIGN cycle fixes signs and writes HI/LO.
module muldiv_ctl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    muldiv_ctl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_ma, r_mb, r_orig_a, r_acc_hi, r_acc_lo;
    logic               r_neg_q, r_neg_r;

    logic               w_accept, w_wr_ok, w_busy, w_signed;
    logic               w_a_neg, w_b_neg, w_ge;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_div_hi, w_div_lo, w_diff;
    logic [WIDTH:0]     w_add, w_shift;
    logic [2*WIDTH-1:0] w_mul_next, w_prod_neg;
    logic [WIDTH-1:0]   w_res_hi, w_res_lo;

    assign w_busy       = (r_state != S_IDLE);
    assign bus.Busy     = w_busy;
    assign bus.Done     = r_done;
    assign bus.Hi       = r_hi;
    assign bus.Lo       = r_lo;
    assign bus.Stall_EX = w_busy & ~bus.flush &
                          (bus.Start_EX | bus.ReadHiLo_EX | bus.WrHi_EX | bus.WrLo_EX);

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_wr_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Start_EX && !bus.flush) begin
                    w_next   = S_RUN;
                    w_accept = 1'b1;
                end else if (!bus.flush) begin
                    w_wr_ok  = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.flush)                           w_next = S_IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))     w_next = S_SIGN;
            end
            S_SIGN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Operand magnitudes; unsigned ops (Op_EX[0]=1) pass through untouched.
    assign w_a_neg = ~bus.Op_EX[0] & bus.SrcA_EX[WIDTH-1];
    assign w_b_neg = ~bus.Op_EX[0] & bus.SrcB_EX[WIDTH-1];
    assign w_a_mag = w_a_neg ? ('0 - bus.SrcA_EX) : bus.SrcA_EX;
    assign w_b_mag = w_b_neg ? ('0 - bus.SrcB_EX) : bus.SrcB_EX;

    // Multiply: add multiplicand on the low bit, then shift {carry,acc_hi,acc_lo} right.
    assign w_add      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_ma} : '0);
    assign w_mul_next = {w_add, r_acc_lo[WIDTH-1:1]};

    // Divide: partial remainder stays below the divisor, so the W-bit difference is exact.
    assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_mb});
    assign w_diff   = w_shift[WIDTH-1:0] - r_mb;
    assign w_div_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_acc_lo[WIDTH-2:0], w_ge};

    // NOTE: the working registers carry no reset; they are always reloaded on accept before being read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= bus.Op_EX;
            r_ma     <= w_a_mag;
            r_mb     <= w_b_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_orig_a <= bus.SrcA_EX;
            r_acc_hi <= '0;
            r_acc_lo <= bus.Op_EX[1] ? w_a_mag : w_b_mag;
        end else if (r_state == S_RUN) begin
            if (r_op[1]) begin
                r_acc_hi <= w_div_hi;
                r_acc_lo <= w_div_lo;
            end else begin
                {r_acc_hi, r_acc_lo} <= w_mul_next;
            end
        end
    end

    assign w_signed   = ~r_op[0];
    assign w_prod_neg = '0 - {r_acc_hi, r_acc_lo};

    always_comb begin
        w_res_hi = r_acc_hi;
        w_res_lo = r_acc_lo;
        if (!r_op[1]) begin
            if (w_signed && r_neg_q) {w_res_hi, w_res_lo} = w_prod_neg;
        end else if (r_mb == '0) begin
            w_res_hi = r_orig_a;
            w_res_lo = '1;
        end else begin
            if (w_signed && r_neg_q) w_res_lo = '0 - r_acc_lo;
            if (w_signed && r_neg_r) w_res_hi = '0 - r_acc_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_cnt  <= (r_state == S_RUN && !bus.flush) ? r_cnt + CNT_W'(1) : '0;
            r_done <= (r_state == S_SIGN) && !bus.flush;
            if (r_state == S_SIGN && !bus.flush) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_wr_ok) begin
                if (bus.WrHi_EX) r_hi <= bus.SrcA_EX;
                if (bus.WrLo_EX) r_lo <= bus.SrcA_EX;
            end
        end
    end
endmodule
